// File: rtl/btn_cond_pkg.sv
// Shared types and channel indices for the front-panel button conditioner.
package btn_cond_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_e;

   localparam int N_BTN      = 5;
   localparam int BTN_UP     = 0;
   localparam int BTN_DOWN   = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_CENTER = 4;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, counter debouncer and hold-to-repeat FSM.
module btn_channel
   import btn_cond_pkg::*;
#(
   parameter int DB_CYCLES    = 1_000_000,
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 10_000_000,
   parameter bit REPEAT_EN    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic pulse
);

   localparam int DB_W   = $clog2(DB_CYCLES + 1);
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W   = $clog2(RP_MAX);
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

   if (DB_CYCLES < 2) begin : g_bad_db
      $error("btn_channel: DB_CYCLES must be at least 2");
   end
   if (REPEAT_RATE < 2) begin : g_bad_rate
      $error("btn_channel: REPEAT_RATE must be at least 2");
   end

   logic [1:0]      sync_r;
   logic            stable_r;
   logic [DB_W-1:0] db_cnt_r;
   btn_state_e      state_r;
   logic [RP_W-1:0] rp_cnt_r;
   logic            pulse_r;

   // two-flop synchronizer for the asynchronous button level
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], btn};
      end
   end

   // debouncer: accept a new level only after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_r <= 1'b0;
         db_cnt_r <= '0;
      end else if (sync_r[1] == stable_r) begin
         db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
         stable_r <= ~stable_r;
         db_cnt_r <= '0;
      end else begin
         db_cnt_r <= db_cnt_r + DB_W'(1);
      end
   end

   // repeat FSM: one pulse on press, then timed repeats while held if enabled
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         rp_cnt_r <= '0;
         pulse_r  <= 1'b0;
      end else begin
         pulse_r <= 1'b0;
         if (!stable_r) begin
            state_r  <= ST_IDLE;
            rp_cnt_r <= '0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r  <= ST_DELAY;
                  rp_cnt_r <= '0;
                  pulse_r  <= 1'b1;
               end
               ST_DELAY: begin
                  if (!REPEAT_EN) begin
                     rp_cnt_r <= '0;
                  end else if (rp_cnt_r == DELAY_LAST) begin
                     state_r  <= ST_REPEAT;
                     rp_cnt_r <= '0;
                     pulse_r  <= 1'b1;
                  end else begin
                     rp_cnt_r <= rp_cnt_r + RP_W'(1);
                  end
               end
               ST_REPEAT: begin
                  if (rp_cnt_r == RATE_LAST) begin
                     rp_cnt_r <= '0;
                     pulse_r  <= 1'b1;
                  end else begin
                     rp_cnt_r <= rp_cnt_r + RP_W'(1);
                  end
               end
               default: begin
                  state_r  <= ST_IDLE;
                  rp_cnt_r <= '0;
               end
            endcase
         end
      end
   end

   assign level = stable_r;
   assign pulse = pulse_r;

endmodule

// File: rtl/btn_pulse_conditioner.sv
// Five-button front-panel conditioner: per-channel debounce/repeat, UP/DOWN
// conflict suppression and registered step pulses for the RTC control block.
module btn_pulse_conditioner
   import btn_cond_pkg::*;
#(
   parameter int         DB_CYCLES    = 1_000_000,
   parameter int         REPEAT_DELAY = 50_000_000,
   parameter int         REPEAT_RATE  = 10_000_000,
   parameter logic [4:0] REPEAT_MASK  = 5'b00011
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_center,
   output logic       enUP,
   output logic       enDOWN,
   output logic       enLEFT,
   output logic       enRIGHT,
   output logic       desactivar_alarma,
   output logic [4:0] btn_level
);

   logic [N_BTN-1:0] raw_s;
   logic [N_BTN-1:0] level_s;
   logic [N_BTN-1:0] pulse_s;
   logic             conflict_r;

   assign raw_s = {btn_center, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DB_CYCLES   (DB_CYCLES),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE),
         .REPEAT_EN   (REPEAT_MASK[i])
      ) u_ch (
         .clk  (clk),
         .reset(reset),
         .btn  (raw_s[i]),
         .level(level_s[i]),
         .pulse(pulse_s[i])
      );
   end

   // output registers; conflict_r is aligned with the cycle each raw pulse was produced
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_r        <= 1'b0;
         enUP              <= 1'b0;
         enDOWN            <= 1'b0;
         enLEFT            <= 1'b0;
         enRIGHT           <= 1'b0;
         desactivar_alarma <= 1'b0;
         btn_level         <= 5'b00000;
      end else begin
         conflict_r        <= level_s[BTN_UP] & level_s[BTN_DOWN];
         enUP              <= pulse_s[BTN_UP] & ~conflict_r;
         enDOWN            <= pulse_s[BTN_DOWN] & ~conflict_r;
         enLEFT            <= pulse_s[BTN_LEFT];
         enRIGHT           <= pulse_s[BTN_RIGHT];
         desactivar_alarma <= pulse_s[BTN_CENTER];
         btn_level         <= level_s;
      end
   end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Bench for btn_pulse_conditioner with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
module tb_btn_pulse_conditioner;

   localparam int N_SCEN = 6;

   typedef struct {
      int         scen;
      int         t0;
      int         t1;
      logic [4:0] btn;
      logic       rst;
   } seg_t;

   typedef struct {
      int         scen;
      int         t;
      logic [4:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, btn_left, btn_right, btn_center;
   logic       enUP, enDOWN, enLEFT, enRIGHT, desactivar_alarma;
   logic [4:0] btn_level;

   seg_t segs[$];
   exp_t pulses[$];
   exp_t levels[$];
   exp_t sb[$];
   int   scen_len[N_SCEN];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   btn_pulse_conditioner #(
      .DB_CYCLES   (4),
      .REPEAT_DELAY(20),
      .REPEAT_RATE (8),
      .REPEAT_MASK (5'b00011)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .btn_up           (btn_up),
      .btn_down         (btn_down),
      .btn_left         (btn_left),
      .btn_right        (btn_right),
      .btn_center       (btn_center),
      .enUP             (enUP),
      .enDOWN           (enDOWN),
      .enLEFT           (enLEFT),
      .enRIGHT          (enRIGHT),
      .desactivar_alarma(desactivar_alarma),
      .btn_level        (btn_level)
   );

   function automatic void add_seg(input int s, input int t0, input int t1,
                                   input logic [4:0] b, input logic r);
      seg_t e;
      e.scen = s; e.t0 = t0; e.t1 = t1; e.btn = b; e.rst = r;
      segs.push_back(e);
   endfunction

   function automatic void add_exp(input int s, input int t, input logic [4:0] v, input bit is_lvl);
      exp_t e;
      e.scen = s; e.t = t; e.val = v;
      if (is_lvl) levels.push_back(e);
      else        pulses.push_back(e);
   endfunction

   task automatic check5(input string what, input int s, input int t,
                         input logic [4:0] got, input logic [4:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s scen=%0d t=%0d got=%b want=%b", what, s, t, got, want);
      end
   endtask

   task automatic drive(input logic [4:0] b, input logic r);
      {btn_center, btn_right, btn_left, btn_down, btn_up} = b;
      reset = r;
   endtask

   task automatic run_scen(input int s);
      logic [4:0] b;
      logic       r;
      logic [4:0] got;
      logic [4:0] want;
      drive(5'b00000, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check5("reset_out", s, -1, {desactivar_alarma, enRIGHT, enLEFT, enDOWN, enUP}, 5'b00000);
      check5("reset_lvl", s, -1, btn_level, 5'b00000);
      sb.delete();
      foreach (pulses[i]) if (pulses[i].scen == s) sb.push_back(pulses[i]);
      for (int t = 0; t < scen_len[s]; t++) begin
         b = 5'b00000;
         r = 1'b0;
         foreach (segs[i]) begin
            if (segs[i].scen == s && t >= segs[i].t0 && t < segs[i].t1) begin
               b = b | segs[i].btn;
               r = r | segs[i].rst;
            end
         end
         drive(b, r);
         @(posedge clk);
         #1;
         got  = {desactivar_alarma, enRIGHT, enLEFT, enDOWN, enUP};
         want = 5'b00000;
         if (sb.size() > 0 && sb[0].t == t) want = sb.pop_front().val;
         check5("pulse", s, t, got, want);
         foreach (levels[i]) begin
            if (levels[i].scen == s && levels[i].t == t) check5("level", s, t, btn_level, levels[i].val);
         end
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL pending scen=%0d got=%0d unmatched want=0", s, sb.size());
      end
   endtask

   initial begin
      drive(5'b00000, 1'b1);
      // scenario lengths and stimulus table
      scen_len = '{130, 50, 100, 70, 40, 70};
      add_seg(0, 10, 110, 5'b00100, 1'b0);
      for (int k = 0; k < 8; k++) add_seg(1, 4 * k, 4 * k + 2, 5'b00001, 1'b0);
      add_seg(2, 0, 80, 5'b00010, 1'b0);
      add_seg(3, 0, 70, 5'b00001, 1'b0);
      add_seg(3, 3, 40, 5'b00010, 1'b0);
      add_seg(4, 0, 40, 5'b11000, 1'b0);
      add_seg(5, 0, 70, 5'b00001, 1'b0);
      add_seg(5, 30, 32, 5'b00000, 1'b1);

      // expected output pulses, ascending cycle per scenario
      add_exp(0, 17, 5'b00100, 1'b0);
      add_exp(2, 7, 5'b00010, 1'b0);
      for (int k = 0; k < 8; k++) add_exp(2, 27 + 8 * k, 5'b00010, 1'b0);
      add_exp(3, 7, 5'b00001, 1'b0);
      add_exp(3, 51, 5'b00001, 1'b0);
      add_exp(3, 59, 5'b00001, 1'b0);
      add_exp(3, 67, 5'b00001, 1'b0);
      add_exp(4, 7, 5'b11000, 1'b0);
      add_exp(5, 7, 5'b00001, 1'b0);
      add_exp(5, 27, 5'b00001, 1'b0);
      add_exp(5, 39, 5'b00001, 1'b0);
      add_exp(5, 59, 5'b00001, 1'b0);
      add_exp(5, 67, 5'b00001, 1'b0);

      // expected debounced levels at selected cycles
      add_exp(0, 15, 5'b00000, 1'b1);
      add_exp(0, 16, 5'b00100, 1'b1);
      add_exp(0, 115, 5'b00100, 1'b1);
      add_exp(0, 116, 5'b00000, 1'b1);
      for (int t = 0; t < 50; t++) add_exp(1, t, 5'b00000, 1'b1);
      add_exp(2, 5, 5'b00000, 1'b1);
      add_exp(2, 6, 5'b00010, 1'b1);
      add_exp(2, 85, 5'b00010, 1'b1);
      add_exp(2, 86, 5'b00000, 1'b1);
      add_exp(3, 6, 5'b00001, 1'b1);
      add_exp(3, 9, 5'b00011, 1'b1);
      add_exp(3, 45, 5'b00011, 1'b1);
      add_exp(3, 46, 5'b00001, 1'b1);
      add_exp(4, 5, 5'b00000, 1'b1);
      add_exp(4, 6, 5'b11000, 1'b1);
      add_exp(5, 29, 5'b00001, 1'b1);
      add_exp(5, 30, 5'b00000, 1'b1);
      add_exp(5, 37, 5'b00000, 1'b1);
      add_exp(5, 38, 5'b00001, 1'b1);

      for (int s = 0; s < N_SCEN; s++) run_scen(s);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
